// File: rtl/stopwatch_core_if.sv
// Control and status bundle between a stopwatch controller and stopwatch_core.
// The master side issues start/stop/clear/lap and observes the count outputs.
interface stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    lap;
    logic [4*NUM_DIGITS-1:0] count;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    running;
    logic                    lap_active;
    logic                    tick;
    logic                    overflow;

    modport master (
        output start, stop, clear, lap,
        input  count, display, running, lap_active, tick, overflow
    );

    modport slave (
        input  start, stop, clear, lap,
        output count, display, running, lap_active, tick, overflow
    );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch timebase: a prescaler divides clk down to TICK_HZ and a chain of
// cascaded BCD digits (each with its own modulus) counts the resulting ticks.
// An explicit IDLE/RUN/PAUSE/HALT machine handles start/stop/clear, and a lap
// snapshot can freeze the display while the live count keeps advancing.
// DIGIT_MODS holds digit0 in [3:0]; the default makes digit1 the tens-of-seconds
// digit (modulus 6) so a 4-digit chain reads m m : s s style up to 99:59.
module stopwatch_core #(
    parameter int                      CLK_HZ      = 50_000_000,
    parameter int                      TICK_HZ     = 10,
    parameter int                      NUM_DIGITS  = 4,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MODS  = {4'd10, 4'd10, 4'd6, 4'd10},
    parameter bit                      STOP_ON_OVF = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_core_if.slave sw
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int W   = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t         state_q,      state_d;
    logic [PW-1:0]  presc_q,      presc_d;
    logic [W-1:0]   count_q,      count_d;
    logic [W-1:0]   display_q,    display_d;
    logic [W-1:0]   snap_q,       snap_d;
    logic           lap_active_q, lap_active_d;
    logic           tick_q,       tick_d;
    logic           overflow_q,   overflow_d;

    logic [W-1:0]   count_inc;
    logic           full_scale;
    logic           ripple;
    logic           presc_wrap;

    // Ripple-increment the digit chain and detect the all-digits-at-max state.
    always_comb begin
        count_inc  = count_q;
        full_scale = 1'b1;
        ripple     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (count_q[4*i +: 4] != (DIGIT_MODS[4*i +: 4] - 4'd1)) begin
                full_scale = 1'b0;
            end
            if (ripple) begin
                if (count_q[4*i +: 4] == (DIGIT_MODS[4*i +: 4] - 4'd1)) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    ripple              = 1'b0;
                end
            end
        end
    end

    // Next-state logic: clear beats everything, stop beats start, the prescaler
    // and digits only move in RUN, and lap toggles the snapshot outside IDLE.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        count_d      = count_q;
        snap_d       = snap_q;
        lap_active_d = lap_active_q;
        tick_d       = 1'b0;
        overflow_d   = overflow_q;
        presc_wrap   = (presc_q == PRESC_MAX);

        if (sw.clear) begin
            state_d      = ST_IDLE;
            presc_d      = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            lap_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sw.start && !sw.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sw.stop) begin
                        state_d = ST_PAUSE;
                    end
                    if (presc_wrap) begin
                        presc_d = '0;
                        if (full_scale) begin
                            overflow_d = 1'b1;
                            if (STOP_ON_OVF) begin
                                state_d = ST_HALT;
                            end else begin
                                count_d = count_inc;
                                tick_d  = 1'b1;
                            end
                        end else begin
                            count_d = count_inc;
                            tick_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (sw.start && !sw.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (sw.lap && (state_q != ST_IDLE)) begin
                if (lap_active_q) begin
                    lap_active_d = 1'b0;
                end else begin
                    lap_active_d = 1'b1;
                    snap_d       = count_q;
                end
            end
        end
    end

    // The display register trails the live count by one cycle or shows the lap snapshot.
    always_comb begin
        display_d = lap_active_q ? snap_q : count_q;
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            count_q      <= '0;
            display_q    <= '0;
            snap_q       <= '0;
            lap_active_q <= 1'b0;
            tick_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            count_q      <= count_d;
            display_q    <= display_d;
            snap_q       <= snap_d;
            lap_active_q <= lap_active_d;
            tick_q       <= tick_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sw.count      = count_q;
    assign sw.display    = display_q;
    assign sw.running    = (state_q == ST_RUN);
    assign sw.lap_active = lap_active_q;
    assign sw.tick       = tick_q;
    assign sw.overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (wrap and halt on overflow) share one
// directed stimulus stream and are compared every cycle against a tick-count model.
module tb_stopwatch_core;

    localparam int          DIV        = 10;
    localparam int          FULL_TICKS = 5999;
    localparam logic [15:0] MODS       = 16'hAA6A;

    logic clk;
    logic reset;
    logic start;
    logic stop;
    logic clear;
    logic lap;
    bit   check_en;

    int assert_count;
    int fail_count;

    // Model state per instance: index 0 wraps on overflow, index 1 halts.
    bit          m_running [2];
    bit          m_halted  [2];
    bit          m_idle    [2];
    int          m_ticks   [2];
    int          m_phase   [2];
    bit          m_ovf     [2];
    bit          m_lap     [2];
    bit          m_tick    [2];
    logic [15:0] m_snap    [2];
    logic [15:0] m_disp    [2];

    logic [15:0] dut_count   [2];
    logic [15:0] dut_display [2];
    logic        dut_running [2];
    logic        dut_lap     [2];
    logic        dut_tick    [2];
    logic        dut_ovf     [2];

    stopwatch_core_if #(.NUM_DIGITS(4)) if0 ();
    stopwatch_core_if #(.NUM_DIGITS(4)) if1 ();

    assign if0.start = start;
    assign if0.stop  = stop;
    assign if0.clear = clear;
    assign if0.lap   = lap;
    assign if1.start = start;
    assign if1.stop  = stop;
    assign if1.clear = clear;
    assign if1.lap   = lap;

    assign dut_count[0]   = if0.count;
    assign dut_display[0] = if0.display;
    assign dut_running[0] = if0.running;
    assign dut_lap[0]     = if0.lap_active;
    assign dut_tick[0]    = if0.tick;
    assign dut_ovf[0]     = if0.overflow;
    assign dut_count[1]   = if1.count;
    assign dut_display[1] = if1.display;
    assign dut_running[1] = if1.running;
    assign dut_lap[1]     = if1.lap_active;
    assign dut_tick[1]    = if1.tick;
    assign dut_ovf[1]     = if1.overflow;

    stopwatch_core #(
        .CLK_HZ(100), .TICK_HZ(10), .NUM_DIGITS(4), .DIGIT_MODS(MODS), .STOP_ON_OVF(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .sw(if0.slave)
    );

    stopwatch_core #(
        .CLK_HZ(100), .TICK_HZ(10), .NUM_DIGITS(4), .DIGIT_MODS(MODS), .STOP_ON_OVF(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .sw(if1.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick count to BCD: tenths-style digit0 mod 10, digit1 mod 6, digits 2/3 mod 10.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 6);
        r[11:8]  = 4'((v / 60) % 10);
        r[15:12] = 4'((v / 600) % 10);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_running[k] = 1'b0;
            m_halted[k]  = 1'b0;
            m_idle[k]    = 1'b1;
            m_ticks[k]   = 0;
            m_phase[k]   = 0;
            m_ovf[k]     = 1'b0;
            m_lap[k]     = 1'b0;
            m_tick[k]    = 1'b0;
            m_snap[k]    = 16'h0000;
            m_disp[k]    = 16'h0000;
        end
    endtask

    // One clock of stopwatch behaviour from the current command inputs.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] live_before;
            bit          was_idle;
            live_before = to_bcd(m_ticks[k]);
            was_idle    = m_idle[k];
            m_disp[k]   = m_lap[k] ? m_snap[k] : live_before;
            m_tick[k]   = 1'b0;
            if (clear) begin
                m_idle[k]    = 1'b1;
                m_running[k] = 1'b0;
                m_halted[k]  = 1'b0;
                m_ticks[k]   = 0;
                m_phase[k]   = 0;
                m_ovf[k]     = 1'b0;
                m_lap[k]     = 1'b0;
            end else begin
                if (m_running[k]) begin
                    m_phase[k]++;
                    if (m_phase[k] == DIV) begin
                        m_phase[k] = 0;
                        if (m_ticks[k] == FULL_TICKS) begin
                            m_ovf[k] = 1'b1;
                            if (k == 1) begin
                                m_halted[k]  = 1'b1;
                                m_running[k] = 1'b0;
                            end else begin
                                m_ticks[k] = 0;
                                m_tick[k]  = 1'b1;
                            end
                        end else begin
                            m_ticks[k]++;
                            m_tick[k] = 1'b1;
                        end
                    end
                    if (stop && !m_halted[k]) m_running[k] = 1'b0;
                end else if (!m_halted[k] && start && !stop) begin
                    m_running[k] = 1'b1;
                    m_idle[k]    = 1'b0;
                end
                if (lap && !was_idle) begin
                    if (m_lap[k]) begin
                        m_lap[k] = 1'b0;
                    end else begin
                        m_lap[k]  = 1'b1;
                        m_snap[k] = live_before;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of commands from a falling edge through to the next falling edge.
    task automatic applyStimulus(input bit s, input bit st, input bit c, input bit l);
        start = s;
        stop  = st;
        clear = c;
        lap   = l;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("dut%0d count", k),      32'(dut_count[k]),   32'(to_bcd(m_ticks[k])));
                checkOutput($sformatf("dut%0d display", k),    32'(dut_display[k]), 32'(m_disp[k]));
                checkOutput($sformatf("dut%0d running", k),    32'(dut_running[k]), 32'(m_running[k]));
                checkOutput($sformatf("dut%0d lap_active", k), 32'(dut_lap[k]),     32'(m_lap[k]));
                checkOutput($sformatf("dut%0d tick", k),       32'(dut_tick[k]),    32'(m_tick[k]));
                checkOutput($sformatf("dut%0d overflow", k),   32'(dut_ovf[k]),     32'(m_ovf[k]));
            end
            if (fail_count > 200) begin
                $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
                $finish;
            end
        end
    end

    initial begin
        assert_count = 0;
        fail_count   = 0;
        check_en     = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        clear        = 1'b0;
        lap          = 1'b0;
        reset        = 1'b1;
        modelReset();

        $display("[TB] reset values");
        #2 reset = 1'b0;
        #1;
        checkOutput("reset count",    32'(if0.count),    32'h0);
        checkOutput("reset display",  32'(if0.display),  32'h0);
        checkOutput("reset running",  32'(if0.running),  32'h0);
        checkOutput("reset overflow", 32'(if1.overflow), 32'h0);
        @(negedge clk);
        reset    = 1'b1;
        check_en = 1'b1;

        $display("[TB] start and tick cadence");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("running after start", 32'(if0.running), 32'h1);
        runCycles(9);
        checkOutput("no tick before DIV", 32'(if0.tick), 32'h0);
        runCycles(1);
        checkOutput("first tick", 32'(if0.tick), 32'h1);
        checkOutput("first tick count", 32'(if0.count), 32'h0001);
        runCycles(240);
        checkOutput("count after 25 ticks", 32'(if0.count), 32'h0025);

        $display("[TB] pause keeps the partial period");
        runCycles(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("running after stop", 32'(if0.running), 32'h0);
        for (int i = 0; i < 29; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("count held in pause", 32'(if0.count), 32'h0025);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("running after resume", 32'(if0.running), 32'h1);
        runCycles(2);
        checkOutput("no tick 2 after resume", 32'(if0.tick), 32'h0);
        runCycles(1);
        checkOutput("tick 3 after resume", 32'(if0.tick), 32'h1);
        checkOutput("count after resume", 32'(if0.count), 32'h0026);

        $display("[TB] minute carry");
        runCycles(5730);
        checkOutput("count at 0959", 32'(if0.count), 32'h0959);
        runCycles(10);
        checkOutput("count at 1000", 32'(if0.count), 32'h1000);

        $display("[TB] full-scale behaviour");
        runCycles(53990);
        checkOutput("dut0 full scale", 32'(if0.count), 32'h9959);
        checkOutput("dut1 full scale", 32'(if1.count), 32'h9959);
        runCycles(10);
        checkOutput("dut0 wrap count",    32'(if0.count),    32'h0000);
        checkOutput("dut0 wrap overflow", 32'(if0.overflow), 32'h1);
        checkOutput("dut0 wrap running",  32'(if0.running),  32'h1);
        checkOutput("dut1 halt count",    32'(if1.count),    32'h9959);
        checkOutput("dut1 halt running",  32'(if1.running),  32'h0);
        checkOutput("dut1 halt overflow", 32'(if1.overflow), 32'h1);
        checkOutput("dut1 halt no tick",  32'(if1.tick),     32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(12);
        checkOutput("dut1 start ignored in halt", 32'(if1.running), 32'h0);
        checkOutput("dut1 count frozen",          32'(if1.count),   32'h9959);
        checkOutput("dut0 counts after wrap",     32'(if0.count),   32'h0001);

        $display("[TB] lap hold");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("dut0 overflow cleared", 32'(if0.overflow), 32'h0);
        checkOutput("dut1 leaves halt count", 32'(if1.count), 32'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(120);
        checkOutput("count at 0012", 32'(if0.count), 32'h0012);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap active", 32'(if0.lap_active), 32'h1);
        runCycles(25);
        checkOutput("count moves during lap", 32'(if0.count),   32'h0014);
        checkOutput("display frozen on lap",  32'(if0.display), 32'h0012);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap released", 32'(if0.lap_active), 32'h0);
        runCycles(1);
        checkOutput("display tracks count", 32'(if0.display), 32'h0014);

        $display("[TB] clear with lap and start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        runCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("clear count",      32'(if0.count),      32'h0);
        checkOutput("clear lap_active", 32'(if0.lap_active), 32'h0);
        checkOutput("clear running",    32'(if0.running),    32'h0);
        checkOutput("clear overflow",   32'(if0.overflow),   32'h0);
        runCycles(15);
        checkOutput("idle stays zero", 32'(if0.count), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap ignored in idle", 32'(if0.lap_active), 32'h0);

        $display("[TB] asynchronous reset mid-tick");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(10);
        checkOutput("tick before reset", 32'(if0.tick), 32'h1);
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset count",   32'(if0.count),   32'h0);
        checkOutput("async reset tick",    32'(if0.tick),    32'h0);
        checkOutput("async reset running", 32'(if0.running), 32'h0);
        checkOutput("async reset display", 32'(if0.display), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        runCycles(20);
        checkOutput("no count after reset", 32'(if0.count),   32'h0);
        checkOutput("stopped after reset",  32'(if0.running), 32'h0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
